// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master arbiter for a single synchronous memory port
// One access per cycle, read data returned one cycle later, bounded bursts per master.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_in
);
    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             last;
    logic             streak;
    logic [CNT_W-1:0] cnt;
    logic             rd_pend;
    logic             rd_who;
    logic             any_gnt;
    logic             winner;
    logic             sel_we;

    // The master that just used its burst allowance yields only when the other is waiting.
    always_comb begin
        any_gnt = (m0_req | m1_req) & resetn;
        winner  = 1'b0;
        if (m0_req && m1_req) begin
            if (streak && (cnt < CNT_MAX)) begin
                winner = last;
            end else begin
                winner = ~last;
            end
        end else if (m1_req) begin
            winner = 1'b1;
        end
    end

    assign m0_gnt = any_gnt & ~winner;
    assign m1_gnt = any_gnt & winner;

    always_comb begin
        mem_address  = '0;
        mem_data_out = '0;
        sel_we       = 1'b0;
        if (any_gnt) begin
            if (winner) begin
                mem_address  = m1_addr;
                mem_data_out = m1_wdata;
                sel_we       = m1_we;
            end else begin
                mem_address  = m0_addr;
                mem_data_out = m0_wdata;
                sel_we       = m0_we;
            end
        end
    end

    assign mem_we = sel_we & any_gnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last    <= 1'b1;
            streak  <= 1'b0;
            cnt     <= '0;
            rd_pend <= 1'b0;
            rd_who  <= 1'b0;
        end else begin
            rd_pend <= any_gnt & ~sel_we;
            rd_who  <= winner;
            streak  <= any_gnt;
            if (!any_gnt) begin
                cnt <= '0;
            end else if (streak && (winner == last)) begin
                if (cnt < CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                cnt  <= CNT_ONE;
                last <= winner;
            end
        end
    end

    // Return path is gated by reset so an in-flight read vanishes the moment reset asserts.
    assign m0_rvalid = resetn & rd_pend & ~rd_who;
    assign m1_rvalid = resetn & rd_pend & rd_who;
    assign m0_rdata  = m0_rvalid ? mem_data_in : '0;
    assign m1_rdata  = m1_rvalid ? mem_data_in : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_address, mem_data_out, mem_data_in;
    logic        mem_we;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_we(mem_we),
        .mem_data_in(mem_data_in)
    );

    always #5 clk = ~clk;

    // Synchronous write-first memory model
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_we) mem[mem_address[7:0]] <= mem_data_out;
        mem_data_in <= mem_we ? mem_data_out : mem[mem_address[7:0]];
    end

    logic [31:0] smem [0:15];

    typedef struct {
        logic r0, r1, g0, g1;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r0, input logic r1, input logic g0, input logic g1, input int n);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.g0 = g0; v.g1 = g1;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 resetn = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: grant history (-1 = idle cycle), last winner, pending read
    int          hist[$];
    int          mlast;
    bit          pv;
    int          pwho;
    logic [31:0] pdata;

    function automatic int trailing_run();
        int n = 0;
        if (hist.size() == 0 || hist[$] == -1) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[$]) break;
            n++;
        end
        return n;
    endfunction

    initial begin
        logic e0, e1, pg0, pg1, h0, h1;
        int w;
        logic [31:0] ea, ed;

        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'h1111_1111;
        for (int i = 0; i < 16; i++) smem[i] = 32'hA500_0000 | i;

        // Reset state with requests present, then single m0 read
        do_reset();
        resetn = 0;
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("rst_m0_gnt", {31'b0, m0_gnt}, 0);
        chk("rst_m1_gnt", {31'b0, m1_gnt}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 0);
        step();
        resetn = 1; m1_req = 0; m0_addr = 32'h10;
        @(negedge clk);
        chk("rd_m0_gnt", {31'b0, m0_gnt}, 1);
        chk("rd_m1_gnt", {31'b0, m1_gnt}, 0);
        chk("rd_addr", mem_address, 32'h10);
        chk("rd_we", {31'b0, mem_we}, 0);
        step();
        m0_req = 0;
        @(negedge clk);
        chk("rd_m0_rvalid", {31'b0, m0_rvalid}, 1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rvalid", {31'b0, m1_rvalid}, 0);
        chk("rd_m1_rdata", m1_rdata, 0);
        chk("rd_idle_addr", mem_address, 0);

        // Table: bursts, saturation, idle gap tie-break
        add(1, 1, 1, 0, 4); add(1, 1, 0, 1, 4); add(1, 1, 1, 0, 2);
        add(0, 0, 0, 0, 1);
        add(0, 1, 0, 1, 6);
        add(1, 1, 1, 0, 4); add(1, 1, 0, 1, 1);
        add(0, 0, 0, 0, 1);
        add(1, 0, 1, 0, 3); add(0, 0, 0, 0, 1); add(1, 1, 0, 1, 1);
        do_reset();
        pg0 = 0; pg1 = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            m0_req = tbl[i].r0; m1_req = tbl[i].r1;
            m0_addr = i; m1_addr = i;
            @(negedge clk);
            chk($sformatf("tbl%0d_g0", i), {31'b0, m0_gnt}, {31'b0, tbl[i].g0});
            chk($sformatf("tbl%0d_g1", i), {31'b0, m1_gnt}, {31'b0, tbl[i].g1});
            chk($sformatf("tbl%0d_rv0", i), {31'b0, m0_rvalid}, {31'b0, pg0});
            chk($sformatf("tbl%0d_rv1", i), {31'b0, m1_rvalid}, {31'b0, pg1});
            pg0 = tbl[i].g0; pg1 = tbl[i].g1;
            step();
        end

        // Simultaneous m1 write / m0 read of the same address
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h55;
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        @(negedge clk);
        chk("wr_m0_gnt", {31'b0, m0_gnt}, 1);
        chk("wr_m1_gnt0", {31'b0, m1_gnt}, 0);
        chk("wr_we0", {31'b0, mem_we}, 0);
        step();
        m0_req = 0;
        @(negedge clk);
        chk("wr_m1_gnt", {31'b0, m1_gnt}, 1);
        chk("wr_we1", {31'b0, mem_we}, 1);
        chk("wr_data", mem_data_out, 32'h55);
        chk("wr_old_rvalid", {31'b0, m0_rvalid}, 1);
        chk("wr_old_rdata", m0_rdata, 32'h1111_1111);
        step();
        m1_req = 0; m1_we = 0; m0_req = 1;
        @(negedge clk);
        chk("wr_we2", {31'b0, mem_we}, 0);
        chk("wr_rd_gnt", {31'b0, m0_gnt}, 1);
        chk("wr_m1_norv", {31'b0, m1_rvalid}, 0);
        step();
        m0_req = 0;
        @(negedge clk);
        chk("wr_new_rdata", m0_rdata, 32'h55);

        // Reset with a read in flight
        do_reset();
        m1_req = 1; m1_addr = 3;
        @(negedge clk);
        chk("pr_m1_gnt", {31'b0, m1_gnt}, 1);
        #1 resetn = 0;
        #1 chk("pr_gnt_forced", {31'b0, m1_gnt}, 0);
        step();
        chk("pr_no_rvalid", {31'b0, m1_rvalid}, 0);
        resetn = 1; m1_req = 0;
        @(negedge clk);
        chk("pr_rel_rv1", {31'b0, m1_rvalid}, 0);
        chk("pr_rel_rv0", {31'b0, m0_rvalid}, 0);
        step();
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("pr_tie_m0", {31'b0, m0_gnt}, 1);
        step();
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        chk("pr_rv_before", {31'b0, m0_rvalid}, 1);
        #1 resetn = 0;
        #1 chk("pr_rv_killed", {31'b0, m0_rvalid}, 0);
        chk("pr_rdata_killed", m0_rdata, 0);
        step();
        resetn = 1;

        // Randomized traffic against the reference model
        do_reset();
        hist.delete(); mlast = 1; pv = 0; pwho = 0; pdata = 0;
        h0 = 0; h1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!h0) begin
                m0_req = ($urandom_range(0, 99) < 60); m0_we = $urandom_range(0, 1);
                m0_addr = $urandom_range(0, 15); m0_wdata = $urandom;
            end
            if (!h1) begin
                m1_req = ($urandom_range(0, 99) < 60); m1_we = $urandom_range(0, 1);
                m1_addr = $urandom_range(0, 15); m1_wdata = $urandom;
            end
            if (m0_req && m1_req)
                w = (hist.size() > 0 && hist[$] != -1 && trailing_run() < MAX_BURST) ? hist[$] : 1 - mlast;
            else if (m0_req) w = 0;
            else if (m1_req) w = 1;
            else w = -1;
            e0 = (w == 0); e1 = (w == 1);
            ea = (w == 0) ? m0_addr : (w == 1) ? m1_addr : 0;
            ed = (w == 0) ? m0_wdata : (w == 1) ? m1_wdata : 0;
            @(negedge clk);
            chk("rnd_g0", {31'b0, m0_gnt}, {31'b0, e0});
            chk("rnd_g1", {31'b0, m1_gnt}, {31'b0, e1});
            chk("rnd_addr", mem_address, ea);
            chk("rnd_wdata", mem_data_out, ed);
            chk("rnd_we", {31'b0, mem_we}, {31'b0, (w == 0 && m0_we) || (w == 1 && m1_we)});
            chk("rnd_rv0", {31'b0, m0_rvalid}, {31'b0, pv && pwho == 0});
            chk("rnd_rv1", {31'b0, m1_rvalid}, {31'b0, pv && pwho == 1});
            chk("rnd_rd0", m0_rdata, (pv && pwho == 0) ? pdata : 0);
            chk("rnd_rd1", m1_rdata, (pv && pwho == 1) ? pdata : 0);
            pv = 0;
            if (w >= 0) begin
                mlast = w;
                if ((w == 0) ? m0_we : m1_we) smem[ea[3:0]] = ed;
                else begin pv = 1; pwho = w; pdata = smem[ea[3:0]]; end
            end
            hist.push_back(w);
            if (hist.size() > MAX_BURST + 2) void'(hist.pop_front());
            h0 = m0_req && !e0;
            h1 = m1_req && !e1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
